serializer_tx: RTL

//  Parallel-to-serial frame transmitter: the transmit end of the 12-bit serial link whose deserializer

---
 rtl/serializer_tx_pkg.sv | 24 ++
 rtl/serializer_tx_bit_tick_gen.sv | 31 +++
 rtl/serializer_tx.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/serializer_tx_pkg.sv
// Shared constants for the serial frame transmitter: FSM encodings, line levels and frame sizing helpers.
package serializer_tx_pkg;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    localparam logic START_LVL = 1'b1;
    localparam logic STOP_LVL  = 1'b0;
    localparam logic IDLE_LVL  = 1'b0;

    // Bit periods per frame: start + data + parity + stop bits.
    function automatic int frame_bits(input int data_w, input int stop_bits);
        return 2 + data_w + stop_bits;
    endfunction

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/serializer_tx_bit_tick_gen.sv
// Bit-period timer: counts clk cycles while enabled and pulses o_tick on the last cycle of each bit period.
module bit_tick_gen
    import serializer_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 1
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_en,
    input  logic i_clr,
    output logic o_tick
);

    localparam int            CW = cnt_width(CLKS_PER_BIT);
    localparam logic [CW-1:0] TC = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= (r_cnt == TC) ? '0 : r_cnt + 1'b1;
        end
    end

    assign o_tick = i_en && !i_clr && (r_cnt == TC);

endmodule

// File: rtl/serializer_tx.sv
// Parallel-to-serial frame transmitter: one-byte holding buffer behind a valid/ready port,
// framed as start '1', data MSB first, parity, stop '0's, with a registered line output.
module serializer_tx
    import serializer_tx_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 1,
    parameter int STOP_BITS    = 2,
    parameter bit PARITY_ODD   = 1'b0
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_data_valid,
    output logic              o_data_ready,
    output logic              o_txd,
    output logic              o_busy,
    output logic              o_frame_done
);

    localparam int            BC_MAX       = (DATA_W > STOP_BITS) ? DATA_W : STOP_BITS;
    localparam int            BW           = cnt_width(BC_MAX);
    localparam logic [BW-1:0] BIT_DATA_TOP = BW'(DATA_W - 1);
    localparam logic [BW-1:0] BIT_STOP_TOP = BW'(STOP_BITS - 1);

    logic [2:0]        r_state;
    logic [DATA_W-1:0] r_hold;
    logic              r_hold_full;
    logic [DATA_W-1:0] r_shift;
    logic [BW-1:0]     r_bit_cnt;
    logic              r_parity;
    logic              r_txd;

    logic [2:0]        w_state_next;
    logic [DATA_W-1:0] w_shift_next;
    logic [BW-1:0]     w_bit_next;
    logic              w_parity_next;
    logic              w_unload;
    logic              w_accept;
    logic              w_tick;
    logic              w_txd_next;
    logic              w_last_stop;

    bit_tick_gen #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_tick (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_en    (r_state != S_IDLE),
        .i_clr   (r_state == S_IDLE),
        .o_tick  (w_tick)
    );

    assign w_accept    = i_data_valid && !r_hold_full;
    assign w_last_stop = (r_state == S_STOP) && w_tick && (r_bit_cnt == '0);

    always_comb begin
        w_state_next  = r_state;
        w_shift_next  = r_shift;
        w_bit_next    = r_bit_cnt;
        w_parity_next = r_parity;
        w_unload      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_hold_full) w_unload = 1'b1;
            end
            S_START: begin
                if (w_tick) begin
                    w_state_next = S_DATA;
                    w_bit_next   = BIT_DATA_TOP;
                end
            end
            S_DATA: begin
                if (w_tick) begin
                    w_shift_next = r_shift << 1;
                    if (r_bit_cnt == '0) w_state_next = S_PARITY;
                    else                 w_bit_next   = r_bit_cnt - 1'b1;
                end
            end
            S_PARITY: begin
                if (w_tick) begin
                    w_state_next = S_STOP;
                    w_bit_next   = BIT_STOP_TOP;
                end
            end
            S_STOP: begin
                if (w_tick) begin
                    if (r_bit_cnt != '0)  w_bit_next   = r_bit_cnt - 1'b1;
                    else if (r_hold_full) w_unload     = 1'b1;
                    else                  w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
        // Unloading from IDLE or from the last stop tick both launch a new frame.
        if (w_unload) begin
            w_state_next  = S_START;
            w_shift_next  = r_hold;
            w_parity_next = (^r_hold) ^ PARITY_ODD;
        end
    end

    // txd is derived from the next state so the line level changes on the same edge as the FSM.
    always_comb begin
        w_txd_next = IDLE_LVL;
        case (w_state_next)
            S_START:  w_txd_next = START_LVL;
            S_DATA:   w_txd_next = w_shift_next[DATA_W-1];
            S_PARITY: w_txd_next = w_parity_next;
            S_STOP:   w_txd_next = STOP_LVL;
            default:  w_txd_next = IDLE_LVL;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= S_IDLE;
            r_hold      <= '0;
            r_hold_full <= 1'b0;
            r_shift     <= '0;
            r_bit_cnt   <= '0;
            r_parity    <= 1'b0;
            r_txd       <= IDLE_LVL;
        end else begin
            r_state   <= w_state_next;
            r_shift   <= w_shift_next;
            r_bit_cnt <= w_bit_next;
            r_parity  <= w_parity_next;
            r_txd     <= w_txd_next;
            if (w_unload) r_hold_full <= 1'b0;
            if (w_accept) begin
                r_hold_full <= 1'b1;
                r_hold      <= i_data;
            end
        end
    end

    assign o_data_ready = ~r_hold_full;
    assign o_txd        = r_txd;
    assign o_busy       = (r_state != S_IDLE);
    assign o_frame_done = w_last_stop;

endmodule
